i2c_switch: RTL and testbench
=============================

I2C_SWITCH -- requirements
Module: i2c_switch

Interface
REQ-001 Parameter PORTS, default 4: number of downstream channels; legal range 2..8.
REQ-002 Parameter MODE, default 0: 0 = mux, one channel at a time (TCA9544A-style); 1 = switch, any subset of channels (TCA9548A-style).
REQ-003 Parameter FILTER_LEN, default 4: glitch-filter depth on the upstream SCL/SDA inputs.
REQ-004 Parameter DEV_ADDR, default 7'h70: 7-bit I2C address of the control register.
REQ-005 Parameter TIMEOUT, default 0: clk cycles a downstream device may hold SCL low before a fault; 0 disables the fault logic.
REQ-006 clk  in  1  sole clock; all logic on posedge clk.
REQ-007 rst  in  1  synchronous reset, active-high.
REQ-008 selected_port  out  PORTS  one bit per channel currently connected.
REQ-009 fault  out  1  sticky stuck-SCL fault flag.
REQ-010 fault_port  out  PORTS  channels that were held low when the fault was raised.
REQ-011 slave_scl_i/slave_sda_i  in  1; slave_scl_o/_t, slave_sda_o/_t  out  1: upstream open-drain bus, where _t = 1 means released and _o = _t.
REQ-012 master_scl_i/master_sda_i  in  PORTS; master_scl_o/_t, master_sda_o/_t  out  PORTS: downstream open-drain buses, where _o = _t.

Function
REQ-013 One 8-bit control register SHALL be readable and writable over the upstream bus at DEV_ADDR, using the existing i2c_single_reg slave.
REQ-014 Register decode in MODE 0, with B = clog2(PORTS): channel reg[B-1:0] is enabled iff reg[B] = 1 and reg[B-1:0] < PORTS; otherwise no channel is enabled.
REQ-015 Register decode in MODE 1: requested mask = reg[PORTS-1:0]; register bits at PORTS and above are ignored.
REQ-016 The bus monitor SHALL detect START (SDA falling while SCL high) and STOP (SDA rising while SCL high) on the filtered upstream lines.
REQ-017 The bus monitor SHALL have two states: IDLE and BUSY. START -> BUSY; STOP -> IDLE; a repeated START stays in BUSY.
REQ-018 Register writes SHALL only update a pending mask.
REQ-019 The active mask SHALL load the pending mask only in IDLE, i.e. on the cycle after a STOP, or immediately if the write ends while IDLE.
REQ-020 A channel SHALL never be connected or disconnected while the monitor is in BUSY, except by a fault (REQ-024).
REQ-021 For each channel k in the active mask, one cycle after the inputs: master_scl_t[k] = slave_scl_i OR NOT slave_scl_t; SDA follows the same rule.
REQ-022 Channels not in the active mask SHALL drive _t = 1.
REQ-023 Upstream: slave_scl_t = (internal register-slave SCL release) AND, over all active k, (master_scl_i[k] OR NOT master_scl_t[k]), registered with 1-cycle latency; SDA follows the same rule. With the mask empty, only the register slave drives the upstream bus.
REQ-024 Stuck-SCL counter:
- Counts while TIMEOUT > 0 and any active channel k has master_scl_t[k] = 1 and master_scl_i[k] = 0.
- Clears on any cycle where that condition is false.
- Saturates at TIMEOUT.
REQ-025 On the cycle the counter reaches TIMEOUT:
- fault <= 1.
- fault_port <= set of channels meeting the REQ-024 condition.
- Active and pending masks <= 0, so all channels are released on the next cycle.
REQ-026 While fault = 1, the active mask SHALL remain 0 regardless of register writes.
REQ-027 fault and fault_port SHALL clear only on rst, or when a register value of 0 is applied in IDLE; a later nonzero write then reconnects normally.
REQ-028 selected_port SHALL equal the active mask.
REQ-029 When a fault and a mask load occur in the same cycle, the fault takes priority.

Reset
REQ-030 While rst is high, the following SHALL hold on the next edge:
- all _t and _o outputs = 1;
- register, pending mask and active mask = 0;
- selected_port = 0, fault = 0, fault_port = 0;
- counter = 0;
- monitor = IDLE.
REQ-031 rst asserted mid-transaction SHALL release every line within one cycle; no STOP is needed.

Verification
REQ-032 MODE 0, PORTS 4: write 0x05 to 0x70, then STOP -> selected_port = 0010 one cycle after STOP; before STOP selected_port = 0000.
REQ-033 MODE 1, PORTS 8: write 0xA5, then STOP -> selected_port = 0xA5. A downstream device on channel 2 pulls SDA low -> slave_sda_t = 0 within 2 cycles.
REQ-034 MODE 1: with mask 0x03 active, write 0x01, repeated START, then read -> mask stays 0x03 until the final STOP, then becomes 0x01.
REQ-035 TIMEOUT = 100, mask 0x04: channel 2 holds SCL low for 100 cycles -> fault = 1, fault_port = 0x04, selected_port = 0. Then write 0x04 + STOP -> still 0. Then write 0x00 + STOP -> fault = 0. Then write 0x04 + STOP -> selected_port = 0x04.
REQ-036 Assert rst during a data byte with channel 1 connected -> all _t = 1 and selected_port = 0 on the next cycle; a register read afterwards returns 0x00.
REQ-037 MODE 0, PORTS 4: write 0x03 (enable bit clear) -> selected_port = 0 after STOP.

Source files
------------

// File: rtl/i2c_switch.sv
// rtl/i2c_switch.sv - I2C channel mux/switch with control-register slave, bus monitor and stuck-SCL fault
module i2c_single_reg #(
    parameter logic [6:0] DEV_ADDR = 7'h70
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sda,
    input  logic       scl_rise,
    input  logic       scl_fall,
    input  logic       start,
    input  logic       stop,
    output logic       sda_t,
    output logic [7:0] reg_value,
    output logic       wr_pulse
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_AACK, S_WR, S_WACK, S_RD, S_RACK} state_t;
    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d, reg_q, reg_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rw_q, rw_d, nack_q, nack_d, wr_q, wr_d;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            reg_q   <= '0;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            nack_q  <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            nack_q  <= nack_d;
            wr_q    <= wr_d;
        end
    end

    // Next-state: bits are sampled on SCL rise, the slave's own SDA changes after SCL fall
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
        nack_d  = nack_q;
        wr_d    = 1'b0;
        if (start) begin
            state_d = S_ADDR;
            cnt_d   = '0;
        end else if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_ADDR, S_WR: begin
                    if (scl_rise) begin
                        sr_d  = {sr_q[6:0], sda};
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        if (state_q == S_WR) begin
                            reg_d   = sr_q;
                            wr_d    = 1'b1;
                            state_d = S_WACK;
                        end else if (sr_q[7:1] == DEV_ADDR) begin
                            rw_d    = sr_q[0];
                            state_d = S_AACK;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_AACK, S_WACK: begin
                    if (scl_fall) begin
                        cnt_d = '0;
                        if (state_q == S_AACK && rw_q) begin
                            state_d = S_RD;
                            sr_d    = reg_q;
                        end else begin
                            state_d = S_WR;
                        end
                    end
                end
                S_RD: begin
                    if (scl_fall) begin
                        sr_d  = {sr_q[6:0], 1'b1};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) state_d = S_RACK;
                    end
                end
                S_RACK: begin
                    if (scl_rise) begin
                        nack_d = sda;
                    end else if (scl_fall) begin
                        cnt_d   = '0;
                        sr_d    = reg_q;
                        state_d = nack_q ? S_IDLE : S_RD;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: ACK slots pull SDA low, read slots present the shift-register MSB
    always_comb begin
        sda_t     = !(state_q == S_AACK || state_q == S_WACK) && (state_q != S_RD || sr_q[7]);
        reg_value = reg_q;
        wr_pulse  = wr_q;
    end
endmodule

module i2c_switch #(
    parameter int         PORTS      = 4,
    parameter int         MODE       = 0,
    parameter int         FILTER_LEN = 4,
    parameter logic [6:0] DEV_ADDR   = 7'h70,
    parameter int         TIMEOUT    = 0
) (
    input  logic             clk,
    input  logic             rst,
    output logic [PORTS-1:0] selected_port,
    output logic             fault,
    output logic [PORTS-1:0] fault_port,
    input  logic             slave_scl_i,
    input  logic             slave_sda_i,
    output logic             slave_scl_o,
    output logic             slave_scl_t,
    output logic             slave_sda_o,
    output logic             slave_sda_t,
    input  logic [PORTS-1:0] master_scl_i,
    input  logic [PORTS-1:0] master_sda_i,
    output logic [PORTS-1:0] master_scl_o,
    output logic [PORTS-1:0] master_scl_t,
    output logic [PORTS-1:0] master_sda_o,
    output logic [PORTS-1:0] master_sda_t
);
    localparam int B  = $clog2(PORTS);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    typedef enum logic {M_IDLE, M_BUSY} mon_t;
    mon_t mon_q, mon_d;

    logic [FILTER_LEN-1:0] scl_sh_q, scl_sh_d, sda_sh_q, sda_sh_d;
    logic scl_f_q, scl_f_d, sda_f_q, sda_f_d, scl_p_q, scl_p_d, sda_p_q, sda_p_d;
    logic start, stop, scl_rise, scl_fall, bus_idle, reg_sda_t, wr_pulse;
    logic [7:0] reg_value;
    logic [PORTS-1:0] dec_mask, stuck, pend_q, pend_d, act_q, act_d, fport_q, fport_d;
    logic [PORTS-1:0] mscl_t_q, mscl_t_d, msda_t_q, msda_t_d;
    logic fault_q, fault_d, sscl_t_q, sscl_t_d, ssda_t_q, ssda_t_d;
    logic [CW-1:0] cnt_q, cnt_d;

    i2c_single_reg #(.DEV_ADDR(DEV_ADDR)) u_reg (
        .clk(clk), .rst(rst), .sda(sda_f_q), .scl_rise(scl_rise), .scl_fall(scl_fall),
        .start(start), .stop(stop), .sda_t(reg_sda_t), .reg_value(reg_value), .wr_pulse(wr_pulse)
    );

    // Datapath registers; reset releases every line immediately
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sh_q <= '1;  sda_sh_q <= '1;
            scl_f_q  <= 1'b1; sda_f_q <= 1'b1; scl_p_q <= 1'b1; sda_p_q <= 1'b1;
            pend_q   <= '0;  act_q    <= '0;  fport_q <= '0;  fault_q <= 1'b0;
            cnt_q    <= '0;
            mscl_t_q <= '1;  msda_t_q <= '1;  sscl_t_q <= 1'b1; ssda_t_q <= 1'b1;
        end else begin
            scl_sh_q <= scl_sh_d; sda_sh_q <= sda_sh_d;
            scl_f_q  <= scl_f_d;  sda_f_q  <= sda_f_d; scl_p_q <= scl_p_d; sda_p_q <= sda_p_d;
            pend_q   <= pend_d;   act_q    <= act_d;   fport_q <= fport_d; fault_q <= fault_d;
            cnt_q    <= cnt_d;
            mscl_t_q <= mscl_t_d; msda_t_q <= msda_t_d; sscl_t_q <= sscl_t_d; ssda_t_q <= ssda_t_d;
        end
    end

    // Glitch filter: a filtered line only moves once the whole history agrees
    always_comb begin
        scl_sh_d = (scl_sh_q << 1) | FILTER_LEN'(slave_scl_i);
        sda_sh_d = (sda_sh_q << 1) | FILTER_LEN'(slave_sda_i);
        scl_f_d  = (&scl_sh_q) ? 1'b1 : ((|scl_sh_q) ? scl_f_q : 1'b0);
        sda_f_d  = (&sda_sh_q) ? 1'b1 : ((|sda_sh_q) ? sda_f_q : 1'b0);
        scl_p_d  = scl_f_q;
        sda_p_d  = sda_f_q;
        start    = scl_f_q & scl_p_q & sda_p_q & ~sda_f_q;
        stop     = scl_f_q & scl_p_q & ~sda_p_q & sda_f_q;
        scl_rise = scl_f_q & ~scl_p_q;
        scl_fall = ~scl_f_q & scl_p_q;
    end

    // Bus monitor state register
    always_ff @(posedge clk) begin
        if (rst) mon_q <= M_IDLE;
        else     mon_q <= mon_d;
    end

    // Bus monitor next state: a repeated START leaves it in BUSY
    always_comb begin
        mon_d = mon_q;
        if (start)     mon_d = M_BUSY;
        else if (stop) mon_d = M_IDLE;
    end

    // Bus monitor output
    always_comb bus_idle = (mon_q == M_IDLE);

    // Register decode into a channel mask
    always_comb begin
        dec_mask = '0;
        if (MODE == 0) begin
            if (reg_value[B] && (32'(reg_value[B-1:0]) < PORTS))
                dec_mask = PORTS'(1) << reg_value[B-1:0];
        end else begin
            dec_mask = reg_value[PORTS-1:0];
        end
    end

    // Mask, fault and forwarding logic; a fault overrides any mask load in the same cycle
    always_comb begin
        stuck   = act_q & mscl_t_q & ~master_scl_i;
        pend_d  = wr_pulse ? dec_mask : pend_q;
        act_d   = act_q;
        fault_d = fault_q;
        fport_d = fport_q;
        if (bus_idle) begin
            act_d = fault_q ? '0 : pend_q;
            if (fault_q && reg_value == 8'd0) begin
                fault_d = 1'b0;
                fport_d = '0;
            end
        end
        cnt_d = '0;
        if (TIMEOUT > 0 && |stuck) begin
            cnt_d = (cnt_q == TMAX) ? cnt_q : cnt_q + 1'b1;
            if (cnt_q == TMAX - 1'b1) begin
                fault_d = 1'b1;
                fport_d = stuck;
                act_d   = '0;
                pend_d  = '0;
            end
        end
        mscl_t_d = ~act_q | {PORTS{slave_scl_i | ~sscl_t_q}};
        msda_t_d = ~act_q | {PORTS{slave_sda_i | ~ssda_t_q}};
        sscl_t_d = &(~act_q | master_scl_i | ~mscl_t_q);
        ssda_t_d = reg_sda_t & (&(~act_q | master_sda_i | ~msda_t_q));
    end

    assign selected_port = act_q;
    assign fault         = fault_q;
    assign fault_port    = fport_q;
    assign slave_scl_t   = sscl_t_q;
    assign slave_scl_o   = sscl_t_q;
    assign slave_sda_t   = ssda_t_q;
    assign slave_sda_o   = ssda_t_q;
    assign master_scl_t  = mscl_t_q;
    assign master_scl_o  = mscl_t_q;
    assign master_sda_t  = msda_t_q;
    assign master_sda_o  = msda_t_q;
endmodule

// File: tb/tb_i2c_switch.sv
// tb/tb_i2c_switch.sv - directed bench for i2c_switch: mux instance at 0x70, switch instance at 0x71
module tb_i2c_switch;
    localparam int Q = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic m_scl = 1'b1, m_sda = 1'b1;
    logic [7:0] dev_scl = 8'hFF, dev_sda = 8'hFF;
    logic bus_scl, bus_sda;
    int checks = 0, failures = 0;

    logic       u0_scl_o, u0_scl_t, u0_sda_o, u0_sda_t, u0_fault;
    logic [3:0] u0_sel, u0_fport, u0_mscl_o, u0_mscl_t, u0_msda_o, u0_msda_t;
    logic       u1_scl_o, u1_scl_t, u1_sda_o, u1_sda_t, u1_fault;
    logic [7:0] u1_sel, u1_fport, u1_mscl_o, u1_mscl_t, u1_msda_o, u1_msda_t, u1_mscl_i, u1_msda_i;

    assign bus_scl   = m_scl & u0_scl_t & u1_scl_t;
    assign bus_sda   = m_sda & u0_sda_t & u1_sda_t;
    assign u1_mscl_i = u1_mscl_t & dev_scl;
    assign u1_msda_i = u1_msda_t & dev_sda;

    always #5 clk = ~clk;

    i2c_switch #(.PORTS(4), .MODE(0), .FILTER_LEN(4), .DEV_ADDR(7'h70), .TIMEOUT(0)) u0 (
        .clk(clk), .rst(rst), .selected_port(u0_sel), .fault(u0_fault), .fault_port(u0_fport),
        .slave_scl_i(bus_scl), .slave_sda_i(bus_sda),
        .slave_scl_o(u0_scl_o), .slave_scl_t(u0_scl_t), .slave_sda_o(u0_sda_o), .slave_sda_t(u0_sda_t),
        .master_scl_i(u0_mscl_t), .master_sda_i(u0_msda_t),
        .master_scl_o(u0_mscl_o), .master_scl_t(u0_mscl_t), .master_sda_o(u0_msda_o), .master_sda_t(u0_msda_t)
    );

    i2c_switch #(.PORTS(8), .MODE(1), .FILTER_LEN(4), .DEV_ADDR(7'h71), .TIMEOUT(100)) u1 (
        .clk(clk), .rst(rst), .selected_port(u1_sel), .fault(u1_fault), .fault_port(u1_fport),
        .slave_scl_i(bus_scl), .slave_sda_i(bus_sda),
        .slave_scl_o(u1_scl_o), .slave_scl_t(u1_scl_t), .slave_sda_o(u1_sda_o), .slave_sda_t(u1_sda_t),
        .master_scl_i(u1_mscl_i), .master_sda_i(u1_msda_i),
        .master_scl_o(u1_mscl_o), .master_scl_t(u1_mscl_t), .master_sda_o(u1_msda_o), .master_sda_t(u1_msda_t)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_cyc(Q);
        m_scl = 1'b1; wait_cyc(Q);
        m_sda = 1'b0; wait_cyc(Q);
        m_scl = 1'b0; wait_cyc(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_cyc(Q);
        m_scl = 1'b1; wait_cyc(Q);
        m_sda = 1'b1; wait_cyc(Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    wait_cyc(Q);
        m_scl = 1'b1; wait_cyc(2 * Q);
        m_scl = 1'b0; wait_cyc(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wait_cyc(Q);
        m_scl = 1'b1; wait_cyc(Q);
        b = bus_sda;  wait_cyc(Q);
        m_scl = 1'b0; wait_cyc(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        read_bit(a);
        ack = ~a;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        send_bit(~ack);
    endtask

    task automatic reg_write(input logic [6:0] addr, input logic [7:0] d);
        logic ack;
        i2c_start();
        write_byte({addr, 1'b0}, ack);
        check("wr_addr_ack", ack, 1);
        write_byte(d, ack);
        check("wr_data_ack", ack, 1);
        i2c_stop();
        wait_cyc(2 * Q);
    endtask

    task automatic reg_read(input logic [6:0] addr, output logic [7:0] d);
        logic ack;
        i2c_start();
        write_byte({addr, 1'b1}, ack);
        check("rd_addr_ack", ack, 1);
        read_byte(d, 1'b0);
        i2c_stop();
        wait_cyc(2 * Q);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rd;

        // Reset state
        wait_cyc(4);
        check("rst_u0_sel", u0_sel, 0);
        check("rst_u0_fault", u0_fault, 0);
        check("rst_u0_fport", u0_fport, 0);
        check("rst_u0_mscl", {u0_mscl_t, u0_mscl_o}, 8'hFF);
        check("rst_u0_msda", {u0_msda_t, u0_msda_o}, 8'hFF);
        check("rst_u0_slave", {u0_scl_t, u0_scl_o, u0_sda_t, u0_sda_o}, 4'hF);
        check("rst_u1_m", {u1_mscl_t, u1_mscl_o, u1_msda_t, u1_msda_o}, 32'hFFFF_FFFF);
        check("rst_u1_slave", {u1_scl_t, u1_scl_o, u1_sda_t, u1_sda_o}, 4'hF);
        rst = 1'b0;
        wait_cyc(2 * Q);

        // Mux: write 0x05, nothing connects until STOP, then channel 1
        i2c_start();
        write_byte(8'hE0, ack);
        check("mux_addr_ack", ack, 1);
        write_byte(8'h05, ack);
        check("mux_data_ack", ack, 1);
        wait_cyc(2 * Q);
        check("mux_pre_stop", u0_sel, 4'b0000);
        i2c_stop();
        wait_cyc(2 * Q);
        check("mux_post_stop", u0_sel, 4'b0010);
        reg_read(7'h70, rd);
        check("mux_readback", rd, 8'h05);

        // Mux: enable bit clear disconnects everything
        reg_write(7'h70, 8'h03);
        check("mux_enable_clear", u0_sel, 4'b0000);
        reg_write(7'h70, 8'h05);
        check("mux_reconnect", u0_sel, 4'b0010);

        // Switch: arbitrary subset, downstream SDA pull propagates upstream
        reg_write(7'h71, 8'hA5);
        check("sw_mask_a5", u1_sel, 8'hA5);
        dev_sda[2] = 1'b0;
        wait_cyc(2);
        check("sw_sda_up_low", u1_sda_t, 0);
        check("sw_bus_sda_low", bus_sda, 0);
        dev_sda[2] = 1'b1;
        wait_cyc(2 * Q);
        check("sw_sda_up_release", u1_sda_t, 1);
        check("sw_mask_kept", u1_sel, 8'hA5);

        // Switch: mask holds across a repeated START until the final STOP
        reg_write(7'h71, 8'h03);
        check("sw_mask_03", u1_sel, 8'h03);
        i2c_start();
        write_byte(8'hE2, ack);
        check("rs_addr_ack", ack, 1);
        write_byte(8'h01, ack);
        check("rs_data_ack", ack, 1);
        wait_cyc(2 * Q);
        check("rs_mid_mask", u1_sel, 8'h03);
        i2c_start();
        write_byte(8'hE3, ack);
        check("rs_raddr_ack", ack, 1);
        read_byte(rd, 1'b0);
        check("rs_read_value", rd, 8'h01);
        check("rs_before_stop", u1_sel, 8'h03);
        i2c_stop();
        wait_cyc(2 * Q);
        check("rs_after_stop", u1_sel, 8'h01);

        // Switch: stuck SCL on channel 2 raises the fault after 100 cycles
        reg_write(7'h71, 8'h04);
        check("flt_mask_04", u1_sel, 8'h04);
        dev_scl[2] = 1'b0;
        wait_cyc(90);
        check("flt_not_yet", u1_fault, 0);
        check("flt_scl_held", u1_scl_t, 0);
        wait_cyc(15);
        check("flt_raised", u1_fault, 1);
        check("flt_port", u1_fport, 8'h04);
        check("flt_sel_zero", u1_sel, 8'h00);
        check("flt_scl_freed", u1_scl_t, 1);
        dev_scl[2] = 1'b1;
        wait_cyc(Q);
        reg_write(7'h71, 8'h04);
        check("flt_write_blocked", u1_sel, 8'h00);
        check("flt_still_set", u1_fault, 1);
        reg_write(7'h71, 8'h00);
        check("flt_cleared", u1_fault, 0);
        check("flt_port_cleared", u1_fport, 8'h00);
        reg_write(7'h71, 8'h04);
        check("flt_reconnect", u1_sel, 8'h04);

        // Reset mid data byte with mux channel 1 connected
        i2c_start();
        write_byte(8'hE0, ack);
        check("mid_addr_ack", ack, 1);
        send_bit(1'b1);
        send_bit(1'b0);
        check("mid_scl_forwarded", u0_mscl_t[1], 0);
        rst = 1'b1;
        wait_cyc(1);
        check("mid_rst_u0_m", {u0_mscl_t, u0_msda_t}, 8'hFF);
        check("mid_rst_u0_slave", {u0_scl_t, u0_sda_t}, 2'b11);
        check("mid_rst_u0_sel", u0_sel, 0);
        check("mid_rst_u1_sel", u1_sel, 0);
        wait_cyc(2);
        rst = 1'b0;
        m_scl = 1'b1;
        wait_cyc(Q);
        m_sda = 1'b1;
        wait_cyc(2 * Q);
        reg_read(7'h70, rd);
        check("post_rst_readback", rd, 8'h00);
        check("post_rst_sel", u0_sel, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
